// File: rtl/buffered_rx.sv
// buffered_rx: UART 8N1 receiver feeding a 2**DEPTH byte FIFO, read back through a 32-bit status/data word
// Ports:
//   CLK      single clock, rising edge
//   RESET_N  synchronous active-low reset
//   UART_RX  asynchronous serial input, idle high
//   DATA_RE  strobe: pop the FIFO head
//   DATA_WE  strobe: control write, DATA_WD[0]=1 clears the sticky flags
//   DATA_WD  control word
//   DATA_RD  {14'b0, overrun, framing, count[7:0], head[7:0]}
module buffered_rx #(
    parameter int DEPTH        = 5,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        UART_RX,
    input  logic        DATA_RE,
    input  logic        DATA_WE,
    input  logic [31:0] DATA_WD,
    output logic [31:0] DATA_RD
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0] bit_idx, idx_n;
    logic [7:0] shreg, sh_n;
    logic stop_err, err_n;
    logic rx_s1, rx_s2;
    logic push, fe_set;
    logic [7:0] mem [2**DEPTH];
    logic [DEPTH:0] wr, rd, count;
    logic full, empty, pop, wr_en, clr, ferr, ovr;
    logic unused_wd;
    assign unused_wd = ^DATA_WD[31:1];
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            stop_err <= 1'b0;
        end else begin
            rx_s1    <= UART_RX;
            rx_s2    <= rx_s1;
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= idx_n;
            shreg    <= sh_n;
            stop_err <= err_n;
        end
    end
    // Timer counts down to 0; expiry is the cycle it reads 0. In STOP it parks at 0
    // while a framing error waits for the line to return high; stop_err marks that wait
    // so the flag is raised once per bad frame.
    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = bit_idx;
        sh_n    = shreg;
        err_n   = stop_err;
        push    = 1'b0;
        fe_set  = 1'b0;
        case (state)
            IDLE: if (!rx_s2) begin
                state_n = START;
                timer_n = HALF_T;
            end
            START: if (timer != '0) timer_n = timer - 1'b1;
            else if (!rx_s2) begin
                state_n = DATA;
                timer_n = FULL_T;
                idx_n   = '0;
            end else state_n = IDLE;
            DATA: if (timer != '0) timer_n = timer - 1'b1;
            else begin
                sh_n    = {rx_s2, shreg[7:1]};
                timer_n = FULL_T;
                idx_n   = bit_idx + 3'd1;
                state_n = (bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (timer != '0) timer_n = timer - 1'b1;
            else if (rx_s2) begin
                push    = !stop_err;
                err_n   = 1'b0;
                state_n = IDLE;
            end else if (!stop_err) begin
                err_n  = 1'b1;
                fe_set = 1'b1;
            end
        endcase
    end
    assign count = wr - rd;
    assign empty = count == '0;
    assign full  = count == (DEPTH+1)'(2**DEPTH);
    assign pop   = DATA_RE & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign wr_en = push & (~full | pop);
    assign clr   = DATA_WE & DATA_WD[0];
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr   <= '0;
            rd   <= '0;
            ferr <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            wr   <= wr + (DEPTH+1)'(wr_en);
            rd   <= rd + (DEPTH+1)'(pop);
            ferr <= fe_set | (ferr & ~clr);
            ovr  <= (push & ~wr_en) | (ovr & ~clr);
        end
    end
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr[DEPTH-1:0]] <= shreg;
    end
    assign DATA_RD = RESET_N ? {14'd0, ovr, ferr, 8'(count), empty ? 8'h00 : mem[rd[DEPTH-1:0]]} : 32'd0;
endmodule

// File: tb/tb_buffered_rx.sv
// tb_buffered_rx: directed and random frames against a queue-based model of buffered_rx
module tb_buffered_rx;
    localparam int CPB = 16;
    localparam int CAP = 8;
    // edge index (from the first start-bit cycle) of the stop sample:
    // 2 synchronizer edges + half bit + start bit + 8 data bits
    localparam int PUSH_C = 2 + CPB/2 + 9*CPB;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic UART_RX = 1'b1;
    logic DATA_RE = 1'b0;
    logic DATA_WE = 1'b0;
    logic [31:0] DATA_WD = 32'd0;
    logic [31:0] DATA_RD;
    logic [7:0] q[$];
    logic fe = 1'b0;
    logic ovr = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    buffered_rx #(.DEPTH(3), .CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .UART_RX(UART_RX), .DATA_RE(DATA_RE),
        .DATA_WE(DATA_WE), .DATA_WD(DATA_WD), .DATA_RD(DATA_RD)
    );
    always #5 CLK = ~CLK;
    function automatic logic [31:0] exp_rd();
        return {14'd0, ovr, fe, 8'(q.size()), (q.size() > 0) ? q[0] : 8'h00};
    endfunction
    task automatic check(input string tag, input logic [31:0] exp);
        n_cmp++;
        assert (DATA_RD === exp) else begin
            n_bad++;
            $error("FAIL %s: DATA_RD=%h expected %h", tag, DATA_RD, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            UART_RX = 1'b1;
            tick();
            check("idle", exp_rd());
        end
    endtask
    task automatic pop();
        DATA_RE = 1'b1;
        tick();
        DATA_RE = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check("pop", exp_rd());
    endtask
    task automatic clear_flags(input logic [31:0] wd);
        DATA_WE = 1'b1;
        DATA_WD = wd;
        tick();
        DATA_WE = 1'b0;
        DATA_WD = 32'd0;
        if (wd[0]) begin
            fe  = 1'b0;
            ovr = 1'b0;
        end
        check("clear", exp_rd());
    endtask
    // One frame, start bit first; stop_low extra low bit times before the stop bit.
    // re_at / we_at / rst_at pick the cycle of a pop, flag clear or reset (-1 = none).
    task automatic frame(input logic [7:0] b, input int stop_low, input int re_at,
                         input int we_at, input int rst_at, input string tag);
        int nb = 10 + stop_low;
        bit aborted = 1'b0;
        for (int c = 0; c < nb*CPB; c++) begin
            int k = c / CPB;
            UART_RX = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : (k < 9 + stop_low) ? 1'b0 : 1'b1;
            DATA_RE = (c == re_at);
            DATA_WE = (c == we_at);
            DATA_WD = (c == we_at) ? 32'h1 : 32'h0;
            RESET_N = (c != rst_at);
            tick();
            if (c == rst_at) begin
                q.delete();
                fe = 1'b0;
                ovr = 1'b0;
                aborted = 1'b1;
            end else begin
                if (c == we_at) begin
                    fe = 1'b0;
                    ovr = 1'b0;
                end
                if (c == re_at && q.size() > 0) void'(q.pop_front());
                if (c == PUSH_C && !aborted) begin
                    if (stop_low != 0) fe = 1'b1;
                    else if (q.size() < CAP) q.push_back(b);
                    else ovr = 1'b1;
                end
            end
            check(tag, exp_rd());
        end
        UART_RX = 1'b1;
        DATA_RE = 1'b0;
        DATA_WE = 1'b0;
        DATA_WD = 32'd0;
        RESET_N = 1'b1;
    endtask
    initial begin
        #1;
        check("rst_comb", 32'd0);
        tick();
        check("rst_1", 32'd0);
        tick();
        check("rst_2", 32'd0);
        RESET_N = 1'b1;
        idle(5);
        frame(8'hA5, 0, -1, -1, -1, "frame_a5");
        check("a5", 32'h0000_01A5);
        pop();
        check("a5_pop", 32'h0000_0000);
        for (int i = 1; i <= 9; i++) frame(8'(i), 0, -1, -1, -1, "frame_fill");
        check("ovr_full", 32'h0002_0801);
        for (int i = 0; i < 8; i++) pop();
        check("drained", 32'h0002_0000);
        clear_flags(32'h1);
        check("ovr_clr", 32'h0);
        for (int i = 0; i < 4; i++) begin
            UART_RX = 1'b0;
            tick();
            check("glitch", exp_rd());
        end
        idle(30);
        check("glitch_none", 32'h0);
        frame(8'h3C, 0, -1, -1, -1, "frame_3c");
        check("rx3c", 32'h0000_013C);
        pop();
        frame(8'h55, 2, -1, PUSH_C, -1, "frame_ferr");
        check("ferr", 32'h0001_0000);
        clear_flags(32'hFFFF_FFFE);
        check("noclr", 32'h0001_0000);
        clear_flags(32'h1);
        check("ferr_clr", 32'h0);
        for (int i = 0; i < 8; i++) frame(8'($urandom), 0, -1, -1, -1, "frame_fill2");
        frame(8'hE7, 0, PUSH_C, -1, -1, "frame_pushpop");
        n_cmp++;
        assert (DATA_RD[17:8] === 10'h008) else begin
            n_bad++;
            $error("FAIL pushpop_full: ovr/count=%h expected %h", DATA_RD[17:8], 10'h008);
        end
        for (int i = 0; i < 8; i++) pop();
        check("wrap_empty", 32'h0);
        for (int i = 0; i < 20; i++) begin
            int re_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 159)) : -1;
            frame(8'($urandom), 0, re_at, -1, -1, "frame_rand");
            repeat ($urandom_range(0, 2)) pop();
        end
        clear_flags(32'h1);
        while (q.size() > 0) pop();
        frame(8'h12, 0, -1, -1, -1, "frame_pre_rst");
        frame(8'hF5, 0, -1, -1, 5*CPB + 8, "frame_rst");
        check("post_rst", 32'h0);
        idle(200);
        check("rst_no_push", 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
